// File: rtl/poliriscv_mc_pkg.sv
// Shared types and encodings for the PoliRISC-V multicycle controller.
package poliriscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_EXEC_U   = 4'd11,
    S_ALU_WB   = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    DC_ADD = 2'd0,
    DC_R   = 2'd1,
    DC_I   = 2'd2,
    DC_BR  = 2'd3
  } dec_cls_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps instruction class and funct fields to an ALU operation.
module mc_alu_decoder
  import poliriscv_mc_pkg::*;
(
  input  dec_cls_t   cls,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] aluctl
);

  logic alt;
  assign alt = funct7[5];

  always_comb begin
    aluctl = ALU_ADD;
    unique case (1'b1)
      (cls == DC_R), (cls == DC_I): begin
        case (funct3)
          3'b000: aluctl = (cls == DC_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001: aluctl = ALU_SLL;
          3'b010: aluctl = ALU_SLT;
          3'b011: aluctl = ALU_SLTU;
          3'b100: aluctl = ALU_XOR;
          3'b101: aluctl = alt ? ALU_SRA : ALU_SRL;
          3'b110: aluctl = ALU_OR;
          default: aluctl = ALU_AND;
        endcase
      end
      (cls == DC_BR): begin
        case (funct3[2:1])
          2'b00: aluctl = ALU_SUB;
          2'b10: aluctl = ALU_SLT;
          2'b11: aluctl = ALU_SLTU;
          default: aluctl = ALU_ADD;
        endcase
      end
      default: aluctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle sequencing controller for the PoliRISC-V datapath.
// POLIRISCV_MEM_WAIT_EN adds a mem_ready stall on memory states.
module mc_control_fsm
  import poliriscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
`ifdef POLIRISCV_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pcwrite,
  output logic [1:0] pc_sel,
  output logic       irwrite,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic [1:0] alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [3:0] aluctl,
  output logic       regwrite,
  output logic [1:0] wb_sel,
  output logic [3:0] state,
  output logic       halted
);

  state_t   state_q, state_d;
  dec_cls_t dec_cls;
  logic     rdy;
  logic     br_bad;
  logic     br_taken;

`ifdef POLIRISCV_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  // funct3 bits 2 and 0 together decide whether zero means taken
  assign br_bad   = (funct3[2:1] == 2'b01);
  assign br_taken = zero ^ (funct3[2] ^ funct3[0]);

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
          default:           state_d = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_U: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = rdy ? S_FETCH : S_MEM_WR;
      S_BRANCH:   state_d = br_bad ? S_HALT : S_FETCH;
      S_ALU_WB, S_MEM_WB, S_JAL, S_JALR: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    pc_sel   = PC_PLUS4;
    irwrite  = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrc_a = A_RS1;
    alusrc_b = B_RS2;
    regwrite = 1'b0;
    wb_sel   = WB_ALU;
    halted   = 1'b0;
    dec_cls  = DC_ADD;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = rdy;
      end
      S_EXEC_R: dec_cls = DC_R;
      S_EXEC_I: begin
        alusrc_b = B_IMM;
        dec_cls  = DC_I;
      end
      S_EXEC_U: begin
        alusrc_a = (opcode == OP_LUI) ? A_ZERO : A_PC;
        alusrc_b = B_IMM;
      end
      S_ALU_WB: begin
        regwrite = 1'b1;
        pcwrite  = 1'b1;
      end
      S_MEM_ADDR: alusrc_b = B_IMM;
      S_MEM_RD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        regwrite = 1'b1;
        wb_sel   = WB_MDR;
        pcwrite  = 1'b1;
      end
      S_MEM_WR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        pcwrite  = rdy;
      end
      S_BRANCH: begin
        dec_cls = DC_BR;
        pcwrite = !br_bad;
        pc_sel  = (!br_bad && br_taken) ? PC_IMM : PC_PLUS4;
      end
      S_JAL: begin
        regwrite = 1'b1;
        wb_sel   = WB_PC4;
        pcwrite  = 1'b1;
        pc_sel   = PC_IMM;
      end
      S_JALR: begin
        alusrc_b = B_IMM;
        regwrite = 1'b1;
        wb_sel   = WB_PC4;
        pcwrite  = 1'b1;
        pc_sel   = PC_ALU;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .cls    (dec_cls),
    .funct3 (funct3),
    .funct7 (funct7),
    .aluctl (aluctl)
  );

endmodule
